// File: rtl/text_line_sequencer.sv
// text_line_sequencer
// Tracks which character box of a single text line the raster is in and drives the
// per-box ROM base address, box origin and box-active flag one cycle after each pixel.
// Character codes live in a double-buffered store: host writes go to the shadow bank
// and a commit publishes it at the next frame start, so a frame never shows a mix.
module text_line_sequencer #(
    parameter int          NUM_CHARS = 8,
    parameter logic [10:0] X_BOX0    = 11'd88,
    parameter logic [9:0]  Y_BOX     = 10'd32,
    parameter logic [10:0] BOX_W     = 11'd50,
    parameter logic [9:0]  BOX_H     = 10'd40,
    parameter logic [10:0] BOX_PITCH = 11'd56,
    parameter int          CODE_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_index,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              commit,
    output logic              box_on,
    output logic [3:0]        box_index,
    output logic [10:0]       box_x,
    output logic [8:0]        rom_base_addr,
    output logic [10:0]       pix_x_d,
    output logic [9:0]        pix_y_d,
    output logic              commit_busy
);

    // Slot address width; the bank is rounded up to a power of two so any slot index
    // slice is in range. Slots at or beyond NUM_CHARS are never written and stay 0.
    localparam int         SLOT_W   = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int         DEPTH    = 1 << SLOT_W;
    localparam logic [4:0] LAST_COL = 5'(NUM_CHARS);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CODE_W-1:0] bank [2][DEPTH];
    logic              bank_sel;          // bank[bank_sel] is active, the other is shadow

    // Column tracker state: position the next valid pixel will have if the line continues.
    logic [4:0]  col_idx;
    logic [10:0] col_off;
    logic [10:0] col_x;

    // Position of the pixel presented this cycle.
    logic [4:0]        cur_idx;
    logic [10:0]       cur_off;
    logic [10:0]       cur_x;
    logic              in_rows;
    logic              in_box;
    logic [CODE_W-1:0] cur_code;
    logic              wr_fire;
    logic              wr_in_range;
    logic [SLOT_W-1:0] wr_slot;

    // Resolve the current pixel's column: the left edge of box 0 restarts the count.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        cur_idx  = col_idx;
        cur_off  = col_off;
        cur_x    = col_x;
        if (pixel_x == X_BOX0) begin
            cur_idx = '0;
            cur_off = '0;
            cur_x   = X_BOX0;
        end
        in_rows     = (pixel_y >= Y_BOX) && (pixel_y < Y_BOX + BOX_H);
        in_box      = pixel_valid && (cur_idx < LAST_COL) && (cur_off < BOX_W) && in_rows;
        cur_code    = bank[bank_sel][cur_idx[SLOT_W-1:0]];
        wr_fire     = wr_valid && wr_ready;
        wr_in_range = ({1'b0, wr_index} < LAST_COL);
        wr_slot     = wr_index[SLOT_W-1:0];
    end

    // Advance the column counters without a divider: count pixels within a pitch and
    // step the box index / running left-edge sum at each pitch boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always assigned with <= so every flop samples
            // the pre-edge values; blocking = here would create order-dependent logic.
            col_idx <= LAST_COL;
            col_off <= '0;
            col_x   <= X_BOX0;
        end else if (pixel_valid) begin
            if (cur_off == BOX_PITCH - 11'd1) begin
                col_off <= '0;
                if (cur_idx != LAST_COL) begin
                    col_idx <= cur_idx + 5'd1;
                    col_x   <= cur_x + BOX_PITCH;
                end else begin
                    col_idx <= cur_idx;
                    col_x   <= cur_x;
                end
            end else begin
                col_off <= cur_off + 11'd1;
                col_idx <= cur_idx;
                col_x   <= cur_x;
            end
        end else begin
            col_idx <= LAST_COL;
            col_off <= '0;
            col_x   <= X_BOX0;
        end
    end

    // Register the box outputs; index/origin/ROM base read as 0 outside every box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_on        <= 1'b0;
            box_index     <= '0;
            box_x         <= '0;
            rom_base_addr <= '0;
            pix_x_d       <= '0;
            pix_y_d       <= '0;
        end else begin
            box_on        <= in_box;
            box_index     <= in_box ? cur_idx[3:0] : 4'd0;
            box_x         <= in_box ? cur_x : 11'd0;
            rom_base_addr <= in_box ? 9'({cur_code, 3'b000}) : 9'd0;
            pix_x_d       <= pixel_x;
            pix_y_d       <= pixel_y;
        end
    end

    // Character store: host writes land in the shadow bank; SWAP flips the bank select
    // and re-seeds the new shadow from the freshly published bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the code store is cleared on reset because a blank line after reset
            // is visible behaviour; this keeps it in flops rather than a RAM macro.
            bank_sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (state == SWAP) begin
            bank_sel <= ~bank_sel;
            for (int i = 0; i < DEPTH; i++) begin
                bank[bank_sel][i] <= bank[~bank_sel][i];
            end
        end else if (wr_fire && wr_in_range) begin
            bank[~bank_sel][wr_slot] <= wr_code;
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Commit FSM next state and handshake outputs; a frame_start coinciding with the
    // commit is too early, so the swap always waits for a later frame_start.
    always_comb begin
        state_nxt   = state;
        wr_ready    = 1'b0;
        commit_busy = 1'b1;
        case (state)
            IDLE: begin
                wr_ready    = 1'b1;
                commit_busy = 1'b0;
                if (commit) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_text_line_sequencer.sv
// tb_text_line_sequencer
// Scoreboarded bench: every driven cycle pushes the expected registered outputs, which
// are popped and compared on the next falling edge. A probe table of fixed points with
// hand-derived expectations is checked whenever the scan passes one of them.
module tb_text_line_sequencer;

    localparam int X0    = 88;
    localparam int Y0    = 32;
    localparam int BW    = 50;
    localparam int BH    = 40;
    localparam int PITCH = 56;
    localparam int NCH   = 8;

    typedef enum int {M_IDLE, M_PENDING, M_SWAP} mstate_t;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic        pv;
        logic        on;
        logic [3:0]  idx;
        logic [10:0] bx;
        logic [8:0]  rom;
    } exp_t;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic        on;
        logic [3:0]  idx;
        logic [10:0] bx;
        logic        chk_rom;
        logic [8:0]  rom;
    } probe_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_index = '0;
    logic [5:0]  wr_code = '0;
    logic        commit = 1'b0;
    logic        box_on;
    logic [3:0]  box_index;
    logic [10:0] box_x;
    logic [8:0]  rom_base_addr;
    logic [10:0] pix_x_d;
    logic [9:0]  pix_y_d;
    logic        commit_busy;

    int checks = 0;
    int errors = 0;

    exp_t    sb[$];
    probe_t  probes[16];
    mstate_t st_m = M_IDLE;
    logic [5:0] active_m [NCH];
    logic [5:0] shadow_m [NCH];

    text_line_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pixel_valid   (pixel_valid),
        .frame_start   (frame_start),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_index      (wr_index),
        .wr_code       (wr_code),
        .commit        (commit),
        .box_on        (box_on),
        .box_index     (box_index),
        .box_x         (box_x),
        .rom_base_addr (rom_base_addr),
        .pix_x_d       (pix_x_d),
        .pix_y_d       (pix_y_d),
        .commit_busy   (commit_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Spec-level expectation for one pixel, by direct division of the line position.
    function automatic exp_t model_pix(input logic [10:0] x, input logic [9:0] y,
                                       input logic pv);
        exp_t e;
        int   d;
        int   k;
        e.x = x; e.y = y; e.pv = pv;
        e.on = 1'b0; e.idx = '0; e.bx = '0; e.rom = '0;
        if (pv && int'(y) >= Y0 && int'(y) < Y0 + BH && int'(x) >= X0) begin
            d = int'(x) - X0;
            k = d / PITCH;
            if (k < NCH && (d % PITCH) < BW) begin
                e.on  = 1'b1;
                e.idx = 4'(k);
                e.bx  = 11'(X0 + k * PITCH);
                e.rom = {active_m[k], 3'b000};
            end
        end
        return e;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < NCH; i++) begin
            active_m[i] = '0;
            shadow_m[i] = '0;
        end
        st_m = M_IDLE;
        sb.delete();
    endtask

    // One clock cycle: compare last cycle's outputs, drive new inputs, predict.
    task automatic step(input logic [10:0] x, input logic [9:0] y, input logic pv,
                        input logic wv, input logic [3:0] widx, input logic [5:0] wcode,
                        input logic cm, input logic fs);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("box_on(%0d,%0d)", e.x, e.y), box_on, e.on);
            check($sformatf("box_index(%0d,%0d)", e.x, e.y), box_index, e.idx);
            check($sformatf("box_x(%0d,%0d)", e.x, e.y), box_x, e.bx);
            check($sformatf("rom(%0d,%0d)", e.x, e.y), rom_base_addr, e.rom);
            check("pix_x_d", pix_x_d, e.x);
            check("pix_y_d", pix_y_d, e.y);
            for (int i = 0; i < 16; i++) begin
                if (e.pv && probes[i].x == e.x && probes[i].y == e.y) begin
                    check($sformatf("probe%0d_on", i), box_on, probes[i].on);
                    check($sformatf("probe%0d_idx", i), box_index, probes[i].idx);
                    check($sformatf("probe%0d_x", i), box_x, probes[i].bx);
                    if (probes[i].chk_rom)
                        check($sformatf("probe%0d_rom", i), rom_base_addr, probes[i].rom);
                end
            end
        end
        check("wr_ready", wr_ready, st_m == M_IDLE);
        check("commit_busy", commit_busy, st_m != M_IDLE);
        pixel_x = x; pixel_y = y; pixel_valid = pv;
        wr_valid = wv; wr_index = widx; wr_code = wcode;
        commit = cm; frame_start = fs;
        sb.push_back(model_pix(x, y, pv));
        case (st_m)
            M_IDLE: begin
                if (wv && int'(widx) < NCH) shadow_m[widx] = wcode;
                if (cm) st_m = M_PENDING;
            end
            M_PENDING: if (fs) st_m = M_SWAP;
            default: begin
                for (int i = 0; i < NCH; i++) active_m[i] = shadow_m[i];
                st_m = M_IDLE;
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic ctrl(input logic wv, input logic [3:0] widx, input logic [5:0] wcode,
                        input logic cm, input logic fs);
        step('0, '0, 1'b0, wv, widx, wcode, cm, fs);
    endtask

    // Contiguous active line starting before box 0, followed by a blanking cycle.
    task automatic scan_line(input int y);
        for (int x = 80; x <= 600; x++) step(11'(x), 10'(y), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic apply_reset(input bit check_during);
        @(negedge clk);
        rst_n = 1'b0;
        pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0;
        wr_valid = 1'b0; commit = 1'b0; frame_start = 1'b0;
        #1;
        if (check_during) begin
            check("rst_wr_ready", wr_ready, 1'b1);
            check("rst_commit_busy", commit_busy, 1'b0);
            check("rst_box_on", box_on, 1'b0);
            check("rst_box_index", box_index, 4'd0);
            check("rst_box_x", box_x, 11'd0);
            check("rst_rom", rom_base_addr, 9'd0);
            check("rst_pix_x_d", pix_x_d, 11'd0);
            check("rst_pix_y_d", pix_y_d, 10'd0);
        end
        clear_models();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        probes[0]  = '{11'd88,  10'd32, 1'b1, 4'd0, 11'd88,  1'b1, 9'h028};
        probes[1]  = '{11'd88,  10'd50, 1'b1, 4'd0, 11'd88,  1'b0, 9'h000};
        probes[2]  = '{11'd137, 10'd50, 1'b1, 4'd0, 11'd88,  1'b0, 9'h000};
        probes[3]  = '{11'd138, 10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[4]  = '{11'd143, 10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[5]  = '{11'd144, 10'd50, 1'b1, 4'd1, 11'd144, 1'b0, 9'h000};
        probes[6]  = '{11'd193, 10'd50, 1'b1, 4'd1, 11'd144, 1'b0, 9'h000};
        probes[7]  = '{11'd194, 10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[8]  = '{11'd480, 10'd50, 1'b1, 4'd7, 11'd480, 1'b0, 9'h000};
        probes[9]  = '{11'd529, 10'd50, 1'b1, 4'd7, 11'd480, 1'b0, 9'h000};
        probes[10] = '{11'd530, 10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[11] = '{11'd536, 10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[12] = '{11'd100, 10'd72, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[13] = '{11'd100, 10'd31, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};
        probes[14] = '{11'd100, 10'd71, 1'b1, 4'd0, 11'd88,  1'b1, 9'h028};
        probes[15] = '{11'd87,  10'd50, 1'b0, 4'd0, 11'd0,   1'b1, 9'h000};

        // Reset state.
        apply_reset(1'b1);
        idle(2);

        // Publish slot0 = 5; a lone frame_start in IDLE must not swap anything.
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        ctrl(1'b1, 4'd0, 6'd5, 1'b0, 1'b0);
        ctrl(1'b1, 4'd9, 6'h3f, 1'b0, 1'b0);   // out-of-range slot is discarded
        ctrl(1'b0, 4'd0, 6'd0, 1'b1, 1'b0);
        idle(2);
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        idle(3);

        // Geometry: top row, mid row, last row and the rows just outside.
        scan_line(32);
        scan_line(50);
        scan_line(71);
        scan_line(72);
        scan_line(31);

        // Commit without frame_start: old code stays visible, writes blocked.
        ctrl(1'b1, 4'd1, 6'd7, 1'b0, 1'b0);
        ctrl(1'b0, 4'd0, 6'd0, 1'b1, 1'b0);
        idle(2);
        ctrl(1'b1, 4'd4, 6'd2, 1'b0, 1'b0);    // refused while pending
        scan_line(50);
        ctrl(1'b0, 4'd0, 6'd0, 1'b1, 1'b0);    // commit while pending is ignored
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        scan_line(50);

        // Write + commit + frame_start in one IDLE cycle: swap waits for next frame_start.
        ctrl(1'b1, 4'd2, 6'd3, 1'b1, 1'b1);
        idle(3);
        scan_line(50);
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        scan_line(50);

        // Partial write after a swap is incremental on top of the published bank.
        ctrl(1'b1, 4'd7, 6'd63, 1'b1, 1'b0);
        idle(1);
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        scan_line(50);

        // Reset while PENDING drops the commit and clears both banks.
        ctrl(1'b1, 4'd3, 6'd9, 1'b1, 1'b0);
        idle(2);
        apply_reset(1'b1);
        idle(2);
        scan_line(50);
        ctrl(1'b0, 4'd0, 6'd0, 1'b1, 1'b0);
        ctrl(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        scan_line(50);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
